// File: rtl/ptw_axi_reader.sv
// ptw_axi_reader: single-outstanding AXI4 PTE reader for the page-table walker.
// Optional PTW_ALIGN_CHECK_EN: misaligned PTE addresses fault without bus traffic.
module ptw_axi_reader #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ADDR_FROM_TLB_VALID,
  input  logic [ADDR_WIDTH-1:0] ADDR_FROM_TLB,
  input  logic                  FLUSH,
  output logic                  DATA_TO_TLB_VALID,
  output logic [DATA_WIDTH-1:0] DATA_TO_TLB,
  output logic                  ACCESS_ERR,
  output logic                  BUSY,
  output logic                  PROTO_ERR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [ID_WIDTH-1:0]   ARID,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic [2:0]            ARPROT,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic                  RLAST,
  input  logic [ID_WIDTH-1:0]   RID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);

  localparam logic [ID_WIDTH-1:0] AxiId = ID_WIDTH'(AXI_ID);

  typedef enum logic [1:0] {
    IDLE,
    AR_S,
    R_S,
    RET
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  proto_q, proto_d;
  logic                  drop_q, drop_d;

  logic req_ok;
  logic id_ok;
  logic beat_last;

  assign req_ok    = ADDR_FROM_TLB_VALID && !FLUSH;
  assign id_ok     = (RID == AxiId);
  assign beat_last = RVALID && id_ok && RLAST;

  // Next-state logic: walk sequencing, drop tracking and protocol error capture.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    data_d   = data_q;
    err_d    = err_q;
    proto_d  = proto_q;
    drop_d   = drop_q;

    if (state_q != IDLE && ADDR_FROM_TLB_VALID)
      proto_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          araddr_d = ADDR_FROM_TLB;
          err_d    = 1'b0;
          drop_d   = 1'b0;
`ifdef PTW_ALIGN_CHECK_EN
          if (ADDR_FROM_TLB[2:0] != 3'b000) begin
            state_d = RET;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = AR_S;
          end
`else
          state_d = AR_S;
`endif
        end
      end
      AR_S: begin
        if (FLUSH)
          drop_d = 1'b1;
        if (ARREADY)
          state_d = R_S;
      end
      R_S: begin
        if (FLUSH)
          drop_d = 1'b1;
        if (RVALID && !id_ok)
          proto_d = 1'b1;
        if (beat_last) begin
          if (drop_q || FLUSH) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = RET;
            err_d   = RRESP[1];
            data_d  = RRESP[1] ? '0 : RDATA;
          end
        end
      end
      RET: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      proto_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      proto_q  <= proto_d;
      drop_q   <= drop_d;
    end
  end

  assign ARVALID = (state_q == AR_S);
  assign RREADY  = (state_q == R_S);
  assign BUSY    = (state_q != IDLE);
  assign ARADDR  = araddr_q;
  assign ARID    = AxiId;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = 3'd3;
  assign ARBURST = 2'b01;
  assign ARPROT  = 3'b001;

  assign DATA_TO_TLB_VALID = (state_q == RET);
  assign ACCESS_ERR        = (state_q == RET) && err_q;
  assign DATA_TO_TLB       = data_q;
  assign PROTO_ERR         = proto_q;

endmodule
